// File: rtl/mac_sequencer.sv
// Shift-add multiply-accumulate sequencer over a valid/ready operand stream.
// Optional build macro MAC_SEQUENCER_SATURATE_EN: accumulator clamps instead of wrapping.

module adder_8_bit (
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] sum,
   output logic       carry
);
   assign {carry, sum} = {1'b0, a} + {1'b0, b};
endmodule

module mac_sequencer #(
   parameter int LEN_W = 4,
   parameter int ACC_W = 20
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             in_valid,
   input  logic [7:0]       in_a,
   input  logic [7:0]       in_b,
   output logic             in_ready,
   output logic             busy,
   output logic [ACC_W-1:0] acc,
   output logic             done,
   output logic             ovf
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_MUL   = 3'd2,
      ST_ACC   = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t             state_r;
   state_t             state_s;
   logic [LEN_W-1:0]   len_cnt_r;
   logic [15:0]        p_r;
   logic [7:0]         mcand_r;
   logic [2:0]         step_r;
   logic [ACC_W-1:0]   acc_r;
   logic               ovf_r;
   logic               done_r;
   logic               in_ready_r;
   logic               busy_r;

   logic [7:0]         addend_s;
   logic [7:0]         sum_s;
   logic               carry_s;
   logic [ACC_W:0]     acc_sum_s;
   logic [ACC_W-1:0]   acc_next_s;

   // Multiplicand is added only when the current multiplier LSB is set.
   always_comb begin
      addend_s = 8'h00;
      if (p_r[0]) begin
         addend_s = mcand_r;
      end else begin
         addend_s = 8'h00;
      end
   end

   adder_8_bit u_adder (
      .a     (p_r[15:8]),
      .b     (addend_s),
      .sum   (sum_s),
      .carry (carry_s)
   );

   // Accumulate the finished product; carry out of the top bit flags overflow.
   always_comb begin
      acc_sum_s  = {1'b0, acc_r} + {{(ACC_W-15){1'b0}}, p_r};
      acc_next_s = acc_sum_s[ACC_W-1:0];
`ifdef MAC_SEQUENCER_SATURATE_EN
      if (acc_sum_s[ACC_W]) begin
         acc_next_s = {ACC_W{1'b1}};
      end else begin
         acc_next_s = acc_sum_s[ACC_W-1:0];
      end
`endif
   end

   // Next-state decode.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_s = (len == {LEN_W{1'b0}}) ? ST_DONE : ST_FETCH;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_FETCH: begin
            if (in_valid) begin
               state_s = ST_MUL;
            end else begin
               state_s = ST_FETCH;
            end
         end
         ST_MUL: begin
            if (step_r == 3'd7) begin
               state_s = ST_ACC;
            end else begin
               state_s = ST_MUL;
            end
         end
         ST_ACC: begin
            if (len_cnt_r == {{(LEN_W-1){1'b0}}, 1'b1}) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_FETCH;
            end
         end
         ST_DONE: state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // State register; status outputs are registered from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         in_ready_r <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         state_r    <= state_s;
         in_ready_r <= (state_s == ST_FETCH);
         busy_r     <= (state_s != ST_IDLE);
         done_r     <= (state_s == ST_DONE);
      end
   end

   // Datapath: operand capture, shift-add steps, accumulation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_cnt_r <= {LEN_W{1'b0}};
         p_r       <= 16'h0000;
         mcand_r   <= 8'h00;
         step_r    <= 3'd0;
         acc_r     <= {ACC_W{1'b0}};
         ovf_r     <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  len_cnt_r <= len;
                  acc_r     <= {ACC_W{1'b0}};
                  ovf_r     <= 1'b0;
               end
            end
            ST_FETCH: begin
               if (in_valid) begin
                  p_r     <= {8'h00, in_b};
                  mcand_r <= in_a;
                  step_r  <= 3'd0;
               end
            end
            ST_MUL: begin
               // 17-bit {carry,sum,low} shifted right by one
               p_r    <= {carry_s, sum_s, p_r[7:1]};
               step_r <= step_r + 3'd1;
            end
            ST_ACC: begin
               acc_r     <= acc_next_s;
               ovf_r     <= ovf_r | acc_sum_s[ACC_W];
               len_cnt_r <= len_cnt_r - {{(LEN_W-1){1'b0}}, 1'b1};
            end
            ST_DONE: begin
               len_cnt_r <= len_cnt_r;
            end
            default: begin
               len_cnt_r <= len_cnt_r;
            end
         endcase
      end
   end

   assign in_ready = in_ready_r;
   assign busy     = busy_r;
   assign done     = done_r;
   assign acc      = acc_r;
   assign ovf      = ovf_r;

endmodule

// File: doc/mac_sequencer.md
Name: mac_sequencer

Overview:
- Sequences a multiply-accumulate over a vector of 8-bit unsigned operand pairs.
- Each product is formed by an 8-step shift-add multiply on one shared adder_8_bit instance, then added into an ACC_W-bit accumulator.
- Sits between the operand source (valid/ready stream) and the MAC result consumer.
- One product is in flight at a time; the adder is time-shared across all 8 multiply steps.

Parameters:
- LEN_W, 4, width of the vector-length input; maximum vector is 2^LEN_W-1 pairs.
- ACC_W, 20, accumulator width; must be at least 16.

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a new vector; sampled only in IDLE.
- len  input  LEN_W  number of pairs; captured when start is accepted.
- in_valid  input  1  operand pair valid.
- in_a  input  8  multiplicand.
- in_b  input  8  multiplier.
- in_ready  output  1  high only in FETCH; the pair transfers on in_valid & in_ready.
- busy  output  1  high in every state except IDLE.
- acc  output  ACC_W  accumulator; holds its value after done until the next accepted start.
- done  output  1  single-cycle pulse when the vector completes.
- ovf  output  1  sticky flag: accumulator overflow occurred in the current vector.

Behaviour:
- Reset (async, rst_n low): state=IDLE; acc=0, ovf=0, done=0, in_ready=0, busy=0; internal counters and product register cleared. Reset mid-operation aborts the vector immediately; no done is produced.
- IDLE, start=1: capture len, clear acc and ovf.
  - len=0: go to DONE.
  - len!=0: go to FETCH.
- FETCH: in_ready=1. On handshake, load P = {8'h00, in_b}, latch in_a as multiplicand, clear step count, go to MUL. Without in_valid, stay in FETCH indefinitely.
- MUL, 8 cycles: each cycle the adder computes P[15:8] + (P[0] ? mcand : 0) with 8-bit sum and carry. P <= {carry, sum, P[7:0]} >> 1, a 17-bit shift whose result is 16 bits. After step 8, P holds the 16-bit product; go to ACC.
- ACC, 1 cycle: acc <= acc + zero-extended P, wrapping at ACC_W. If the addition carries out of ACC_W, ovf <= 1. Decrement the remaining count. If it reaches 0, go to DONE; otherwise go to FETCH.
- DONE, 1 cycle: done=1, then go to IDLE.
- Latency:
  - 10 cycles per pair when in_valid is held high: 1 FETCH, 8 MUL, 1 ACC.
  - done asserts 1 cycle after the last ACC.
  - Total from the start cycle to the done cycle is 10*len+2 cycles.
- start outside IDLE is ignored. start in the DONE cycle is also ignored; start is accepted again on the cycle after done.
- in_valid outside FETCH is ignored, and in_a/in_b are not sampled.
- busy=1 from the cycle after start is accepted through the DONE cycle inclusive.

Optional Feature:
- Macro: MAC_SEQUENCER_SATURATE_EN.
- Defined: on carry-out in ACC, acc clamps to 2^ACC_W-1 and ovf is set. Once saturated, acc stays at 2^ACC_W-1 for the rest of the vector.
- Undefined: acc wraps modulo 2^ACC_W and ovf is set on carry-out.
- ovf behaviour is identical in both builds.

Test Plan:
- Reset mid-vector: drop rst_n during MUL of pair 2 -> immediately acc=0, busy=0, done=0, in_ready=0; no done pulse after release.
- Single pair: len=1, a=13, b=11, in_valid held high -> done in cycle 12 after start, acc=143, ovf=0.
- Max vector: len=15, all pairs 255x255 -> acc=975375, ovf=0, done exactly once, busy low the cycle after done.
- Backpressure and zero length:
  - len=3, pairs (2,3),(4,5),(6,7), in_valid low for 5 cycles inside each FETCH -> acc=68; in_ready high only in FETCH; pair not consumed while in_valid is low.
  - len=0 -> done 2 cycles after start, acc=0.
- Overflow at ACC_W=16: len=2, both pairs 255x255.
  - Macro undefined -> acc=64514, ovf=1.
  - Macro defined -> acc=65535, ovf=1.
- Ignored start: pulse start with len=5 during MUL of a len=1 run -> run completes with len=1 result; no second vector begins.
